// File: rtl/minimig_autoconfig_mapper.sv
// minimig_autoconfig_mapper: walks the autoconfig chain across the expansion slots, latches each
// slot's base address or shut-up state, and produces a registered per-slot address-hit decode.
module minimig_autoconfig_mapper #(
  parameter int NBOARDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk7_en,
  input  logic                   sel,
  input  logic [7:0]             address_in,
  input  logic [15:0]            data_in,
  input  logic                   hwr,
  input  logic                   lwr,
  input  logic [NBOARDS-1:0]     board_present,
  input  logic [NBOARDS-1:0]     board_z3,
  input  logic [16*NBOARDS-1:0]  board_mask,
  input  logic [15:0]            cpu_addr,
  output logic [2:0]             cur_board,
  output logic                   autoconfig_done,
  output logic [NBOARDS-1:0]     board_configured,
  output logic [NBOARDS-1:0]     board_shutup,
  output logic [16*NBOARDS-1:0]  board_base,
  output logic [NBOARDS-1:0]     hit
);
  typedef enum logic [1:0] {SCAN, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] cur_board_q, cur_board_d;
  logic done_q, done_d, z3_q, z3_d;
  logic [NBOARDS-1:0] configured_q, configured_d, shutup_q, shutup_d, hit_q, hit_d;
  logic [16*NBOARDS-1:0] base_q, base_d;
  logic [NBOARDS-1:0] present_sh, z3_sh;
  logic wr, zii_cfg, ziii_cfg, shut;
  assign present_sh = board_present >> cur_board_q;
  assign z3_sh = board_z3 >> cur_board_q;
  always_comb begin
    wr = clk7_en & sel & (hwr | lwr);
    zii_cfg = wr & ~z3_q & (address_in == 8'h24) & hwr;
    ziii_cfg = wr & z3_q & (address_in == 8'h22) & hwr & lwr;
    shut = wr & (address_in == 8'h26);
    state_d = state_q;
    cur_board_d = cur_board_q;
    done_d = done_q;
    z3_d = z3_q;
    configured_d = configured_q;
    shutup_d = shutup_q;
    base_d = base_q;
    if (state_q == SCAN) begin
      if (32'(cur_board_q) >= NBOARDS) begin
        cur_board_d = 3'b111;
        done_d = 1'b1;
        state_d = DONE;
      end else if (present_sh[0]) begin
        z3_d = z3_sh[0];
        state_d = WAIT;
      end else cur_board_d = cur_board_q + 3'd1;
    end else if (state_q == WAIT && (zii_cfg || ziii_cfg || shut)) begin
      for (int i = 0; i < NBOARDS; i++)
        if (cur_board_q == 3'(i)) begin
          if (shut) shutup_d[i] = 1'b1;
          else begin
            configured_d[i] = 1'b1;
            base_d[16*i +: 16] = ziii_cfg ? data_in : {8'h00, data_in[15:8]};
          end
        end
      cur_board_d = cur_board_q + 3'd1;
      state_d = SCAN;
    end
    for (int i = 0; i < NBOARDS; i++)
      hit_d[i] = configured_q[i] & (((cpu_addr ^ base_q[16*i +: 16]) & board_mask[16*i +: 16]) == 16'h0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      cur_board_q <= 3'd0;
      done_q <= 1'b0;
      z3_q <= 1'b0;
      configured_q <= '0;
      shutup_q <= '0;
      base_q <= '0;
      hit_q <= '0;
    end else begin
      state_q <= state_d;
      cur_board_q <= cur_board_d;
      done_q <= done_d;
      z3_q <= z3_d;
      configured_q <= configured_d;
      shutup_q <= shutup_d;
      base_q <= base_d;
      hit_q <= hit_d;
    end
  end
  assign cur_board = cur_board_q;
  assign autoconfig_done = done_q;
  assign board_configured = configured_q;
  assign board_shutup = shutup_q;
  assign board_base = base_q;
  assign hit = hit_q;
endmodule

// File: tb/tb_minimig_autoconfig_mapper.sv
// tb_minimig_autoconfig_mapper: directed scenario tasks for the autoconfig chain mapper.
module tb_minimig_autoconfig_mapper;
  logic clk = 0, reset = 1, clk7_en = 0, sel = 0, hwr = 0, lwr = 0;
  logic [7:0] address_in = 0;
  logic [15:0] data_in = 0, cpu_addr = 0;
  logic [3:0] board_present = 0, board_z3 = 0;
  logic [63:0] board_mask = {4{16'hFFFF}};
  logic [2:0] cur_board;
  logic autoconfig_done;
  logic [3:0] board_configured, board_shutup, hit;
  logic [63:0] board_base;
  int checks = 0, failures = 0;

  minimig_autoconfig_mapper #(.NBOARDS(4)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .sel(sel), .address_in(address_in),
    .data_in(data_in), .hwr(hwr), .lwr(lwr), .board_present(board_present),
    .board_z3(board_z3), .board_mask(board_mask), .cpu_addr(cpu_addr),
    .cur_board(cur_board), .autoconfig_done(autoconfig_done),
    .board_configured(board_configured), .board_shutup(board_shutup),
    .board_base(board_base), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1;
    step(2);
    reset = 0;
  endtask

  task automatic wr_cycle(input logic [7:0] a, input logic [15:0] d, input logic h, input logic l, input logic c7);
    sel = 1; address_in = a; data_in = d; hwr = h; lwr = l; clk7_en = c7;
    step(1);
    sel = 0; hwr = 0; lwr = 0; clk7_en = 0;
  endtask

  task automatic test_reset();
    board_present = 4'b1111; board_z3 = 4'b0000;
    apply_reset();
    checks++; if (cur_board !== 3'd0) begin failures++; $display("FAIL reset_cur got=%0h exp=0", cur_board); end
    checks++; if (autoconfig_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", autoconfig_done); end
    checks++; if (board_configured !== 4'b0) begin failures++; $display("FAIL reset_cfg got=%b exp=0000", board_configured); end
    checks++; if (board_shutup !== 4'b0) begin failures++; $display("FAIL reset_shut got=%b exp=0000", board_shutup); end
    checks++; if (board_base !== 64'h0) begin failures++; $display("FAIL reset_base got=%h exp=0", board_base); end
    checks++; if (hit !== 4'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0000", hit); end
  endtask

  task automatic test_chain();
    board_present = 4'b1111; board_z3 = 4'b1110; board_mask = {4{16'hFFFF}};
    apply_reset();
    step(2);
    wr_cycle(8'h24, 16'h2000, 1, 0, 1);
    checks++; if (board_base[15:0] !== 16'h0020) begin failures++; $display("FAIL chain_base0 got=%h exp=0020", board_base[15:0]); end
    checks++; if (board_configured !== 4'b0001) begin failures++; $display("FAIL chain_cfg0 got=%b exp=0001", board_configured); end
    checks++; if (cur_board !== 3'd1) begin failures++; $display("FAIL chain_cur1 got=%0h exp=1", cur_board); end
    for (int i = 1; i < 4; i++) begin
      step(2);
      wr_cycle(8'h22, 16'h4000 + 16'(i - 1) * 16'h0200, 1, 1, 1);
    end
    step(2);
    checks++; if (board_configured !== 4'b1111) begin failures++; $display("FAIL chain_cfg got=%b exp=1111", board_configured); end
    checks++; if (cur_board !== 3'b111) begin failures++; $display("FAIL chain_cur got=%0h exp=7", cur_board); end
    checks++; if (autoconfig_done !== 1'b1) begin failures++; $display("FAIL chain_done got=%0b exp=1", autoconfig_done); end
    checks++; if (board_base !== 64'h4400_4200_4000_0020) begin failures++; $display("FAIL chain_bases got=%h exp=4400420040000020", board_base); end
    wr_cycle(8'h22, 16'h7700, 1, 1, 1);
    wr_cycle(8'h26, 16'h0000, 1, 1, 1);
    checks++; if (board_base !== 64'h4400_4200_4000_0020 || board_shutup !== 4'b0) begin failures++; $display("FAIL done_ignore got=%h/%b exp=4400420040000020/0000", board_base, board_shutup); end
  endtask

  task automatic test_skip();
    board_present = 4'b0101; board_z3 = 4'b0000;
    apply_reset();
    step(2);
    checks++; if (cur_board !== 3'd0) begin failures++; $display("FAIL skip_cur0 got=%0h exp=0", cur_board); end
    wr_cycle(8'h24, 16'h1000, 1, 0, 1);
    step(1);
    checks++; if (cur_board !== 3'd2) begin failures++; $display("FAIL skip_cur2 got=%0h exp=2", cur_board); end
    step(1);
    wr_cycle(8'h24, 16'h3000, 1, 0, 1);
    checks++; if (board_configured !== 4'b0101 || autoconfig_done !== 1'b0) begin failures++; $display("FAIL skip_cfg got=%b/%0b exp=0101/0", board_configured, autoconfig_done); end
    step(2);
    checks++; if (autoconfig_done !== 1'b1 || cur_board !== 3'b111) begin failures++; $display("FAIL skip_done got=%0b/%0h exp=1/7", autoconfig_done, cur_board); end
    checks++; if (board_base !== 64'h0000_0030_0000_0010) begin failures++; $display("FAIL skip_base got=%h exp=0000003000000010", board_base); end
  endtask

  task automatic test_shutup();
    board_present = 4'b0001; board_z3 = 4'b0000; board_mask = {{3{16'hFFFF}}, 16'hFFE0};
    cpu_addr = 16'h0020;
    apply_reset();
    step(2);
    wr_cycle(8'h26, 16'h0000, 1, 0, 1);
    checks++; if (board_shutup !== 4'b0001) begin failures++; $display("FAIL shut_bits got=%b exp=0001", board_shutup); end
    checks++; if (board_configured !== 4'b0000) begin failures++; $display("FAIL shut_cfg got=%b exp=0000", board_configured); end
    step(1);
    checks++; if (hit !== 4'b0000) begin failures++; $display("FAIL shut_hit got=%b exp=0000", hit); end
  endtask

  task automatic test_decode();
    board_present = 4'b0001; board_z3 = 4'b0000; board_mask = {{3{16'hFFFF}}, 16'hFFE0};
    cpu_addr = 16'h0000;
    apply_reset();
    step(2);
    wr_cycle(8'h24, 16'h2000, 1, 0, 1);
    cpu_addr = 16'h003F; step(1);
    checks++; if (hit !== 4'b0001) begin failures++; $display("FAIL dec_003f got=%b exp=0001", hit); end
    cpu_addr = 16'h0040; step(1);
    checks++; if (hit !== 4'b0000) begin failures++; $display("FAIL dec_0040 got=%b exp=0000", hit); end
    cpu_addr = 16'h0020; step(1);
    checks++; if (hit !== 4'b0001) begin failures++; $display("FAIL dec_0020 got=%b exp=0001", hit); end
    cpu_addr = 16'h0120; step(1);
    checks++; if (hit !== 4'b0000) begin failures++; $display("FAIL dec_0120 got=%b exp=0000", hit); end
    cpu_addr = 16'h8020; step(1);
    checks++; if (hit !== 4'b0000) begin failures++; $display("FAIL dec_8020 got=%b exp=0000", hit); end
  endtask

  task automatic test_mismatch();
    board_present = 4'b0011; board_z3 = 4'b0010; board_mask = {4{16'hFFFF}};
    apply_reset();
    step(2);
    wr_cycle(8'h22, 16'h5500, 1, 1, 1);
    wr_cycle(8'h24, 16'h5500, 0, 1, 1);
    wr_cycle(8'h24, 16'h5500, 1, 0, 0);
    wr_cycle(8'h20, 16'h5500, 1, 1, 1);
    checks++; if (board_configured !== 4'b0 || cur_board !== 3'd0 || board_base !== 64'h0) begin failures++; $display("FAIL mis_zii got=%b/%0h/%h exp=0000/0/0", board_configured, cur_board, board_base); end
    wr_cycle(8'h24, 16'hAB00, 1, 0, 1);
    checks++; if (cur_board !== 3'd1 || board_base[15:0] !== 16'h00AB) begin failures++; $display("FAIL mis_zii_ok got=%0h/%h exp=1/00ab", cur_board, board_base[15:0]); end
    step(2);
    wr_cycle(8'h24, 16'h5500, 1, 1, 1);
    wr_cycle(8'h22, 16'h5500, 1, 0, 1);
    checks++; if (board_configured !== 4'b0001 || cur_board !== 3'd1 || board_base[31:16] !== 16'h0) begin failures++; $display("FAIL mis_ziii got=%b/%0h/%h exp=0001/1/0", board_configured, cur_board, board_base[31:16]); end
    wr_cycle(8'h22, 16'h6600, 1, 1, 1);
    checks++; if (board_base[31:16] !== 16'h6600 || board_configured !== 4'b0011) begin failures++; $display("FAIL mis_ziii_ok got=%h/%b exp=6600/0011", board_base[31:16], board_configured); end
  endtask

  task automatic test_back_to_back();
    board_present = 4'b1111; board_z3 = 4'b0000;
    apply_reset();
    step(2);
    wr_cycle(8'h24, 16'h1100, 1, 0, 1);
    wr_cycle(8'h24, 16'h2200, 1, 0, 1);
    checks++; if (board_configured !== 4'b0001 || cur_board !== 3'd1) begin failures++; $display("FAIL scan_ignore got=%b/%0h exp=0001/1", board_configured, cur_board); end
    wr_cycle(8'h24, 16'h3300, 1, 0, 1);
    checks++; if (board_configured !== 4'b0011 || board_base[31:0] !== 32'h0033_0011) begin failures++; $display("FAIL slot1 got=%b/%h exp=0011/00330011", board_configured, board_base[31:0]); end
    reset = 1; step(1); reset = 0;
    checks++; if (cur_board !== 3'd0 || board_configured !== 4'b0 || board_base !== 64'h0 || autoconfig_done !== 1'b0) begin failures++; $display("FAIL midreset got=%0h/%b/%h/%0b exp=0/0000/0/0", cur_board, board_configured, board_base, autoconfig_done); end
    step(2);
    wr_cycle(8'h24, 16'h4400, 1, 0, 1);
    checks++; if (cur_board !== 3'd1 || board_configured !== 4'b0001 || board_base[15:0] !== 16'h0044) begin failures++; $display("FAIL restart got=%0h/%b/%h exp=1/0001/0044", cur_board, board_configured, board_base[15:0]); end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_skip();
    test_shutup();
    test_decode();
    test_mismatch();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/minimig_autoconfig_mapper.md
Name: minimig_autoconfig_mapper

Overview:
- Sequences the Amiga autoconfig chain across up to 7 expansion boards (Zorro II and Zorro III).
- Latches the base address the OS writes to each board and handles shut-up requests.
- Provides registered per-board address-hit decode for the fast-RAM datapath.
- Sits between the CPU bus and the SDRAM/fast-RAM selector. Drives the autoconfig ROM board index.

Parameters:
- NBOARDS, 4, number of chain slots (1..7); slot index order is chain order.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- clk7_en  input  1  CPU bus qualifier; autoconfig writes are sampled only when high
- sel  input  1  access is in autoconfig space (ZII 0xE8xxxx or ZIII 0xFF00xxxx)
- address_in  input  8  CPU address bits [8:1] within the autoconfig space
- data_in  input  16  CPU write data
- hwr  input  1  high-byte write
- lwr  input  1  low-byte write
- board_present  input  NBOARDS  slot is populated
- board_z3  input  NBOARDS  1 = Zorro III slot, 0 = Zorro II slot
- board_mask  input  16*NBOARDS  per-slot compare mask over A31:A16; 1 = bit participates
- cpu_addr  input  16  CPU address bits A31:A16 for decode
- cur_board  output  3  slot currently answering autoconfig; 3'b111 = null device
- autoconfig_done  output  1  chain exhausted
- board_configured  output  NBOARDS  base address latched
- board_shutup  output  NBOARDS  slot shut up by the OS
- board_base  output  16*NBOARDS  latched A31:A16 per slot
- hit  output  NBOARDS  registered decode result

Behaviour:
- Reset values:
  - cur_board = 0, autoconfig_done = 0.
  - board_configured, board_shutup, board_base and hit all 0.
  - State = SCAN.
- Reset asserted mid-chain discards all progress.
- SCAN state (runs every clk; not gated by clk7_en):
  - If cur_board ≥ NBOARDS: set cur_board = 3'b111, autoconfig_done = 1, go to DONE.
  - Else if board_present[cur_board]: go to WAIT.
  - Else: increment cur_board and stay in SCAN.
  - Worst-case scan latency is NBOARDS+1 clk.
- WAIT state: act only on clk7_en & sel & (hwr|lwr). The byte offset is {address_in, 0}.
  - ZII slot, offset 0x48 with hwr:
    - board_base[cur] = {8'h00, data_in[15:8]}.
    - Set board_configured[cur].
    - Increment cur_board, go to SCAN.
  - ZIII slot, offset 0x44 with hwr & lwr:
    - board_base[cur] = data_in.
    - Set board_configured[cur].
    - Increment cur_board, go to SCAN.
  - Offset 0x4C (any byte strobe): set board_shutup[cur], increment cur_board, go to SCAN. Base and configured are unchanged.
  - Ignored writes:
    - Any other offset.
    - ZII slot written at 0x44.
    - ZIII slot written at 0x48.
    - ZII write at 0x48 with lwr only.
    - ZIII write at 0x44 missing a strobe.
- DONE state: all writes are ignored. Stays in DONE until reset.
- Writes while in SCAN are ignored.
- board_present and board_z3 are sampled only when the slot is visited in SCAN. Later changes have no effect.
- Decode (every clk, one-cycle latency):
  - hit[i] <= board_configured[i] & (((cpu_addr ^ board_base[i]) & board_mask[i]) == 0).
  - Shut-up or unconfigured slots never hit.
  - Overlapping bases may assert several hit bits; no priority is applied here.
- cur_board, autoconfig_done, board_configured and board_shutup are registered outputs. They update on the clk edge that commits the write.

Test Plan:
- NBOARDS=4, present=4'b1111, z3=4'b1110. Write 0x48 hwr data 0x2000 → base[0]=0x0020, configured=0001, cur_board 1 within 2 clk. Writes to 0x44 of 0x4000, 0x4200, 0x4400 → configured=1111, cur_board=3'b111, autoconfig_done=1.
- present=4'b0101 → cur_board skips 1 (goes 0 → 2) and skips 3. done follows the second commit; configured=0101.
- Slot 0 ZII: write 0x4C → shutup=0001, configured=0000. cpu_addr=0x0020 with mask 0xFFE0 gives hit[0]=0.
- Slot 0 configured at 0x0020, mask 0xFFE0 (2 MB). cpu_addr 0x003F → hit=0001 one clk later; cpu_addr 0x0040 → hit=0000. Any cpu_addr with A31:A24 nonzero → 0.
- Write mismatches leave state unchanged:
  - ZII slot: 0x44 word write, 0x48 lwr-only write, 0x48 write with clk7_en=0.
  - ZIII slot: 0x48 write, and 0x44 write with only hwr.
- Mid-chain reset after slot 1 commit → all outputs return to reset values. Chain restarts at slot 0.
